// File: rtl/spi_flash_pkg.sv
// rtl/spi_flash_pkg.sv - shared opcodes, op encodings, sequencer states and frame helpers
package spi_flash_pkg;

    localparam logic [7:0] CMD_WREN         = 8'h06;
    localparam logic [7:0] CMD_CHIP_ERASE   = 8'hC7;
    localparam logic [7:0] CMD_SECTOR_ERASE = 8'h20;
    localparam logic [7:0] CMD_BLOCK_ERASE  = 8'hD8;
    localparam logic [7:0] CMD_RDSR         = 8'h05;

    localparam logic [1:0] OP_CHIP   = 2'b00;
    localparam logic [1:0] OP_SECTOR = 2'b01;
    localparam logic [1:0] OP_BLOCK  = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WREN,
        ST_GAP1,
        ST_ERASE,
        ST_GAP2,
        ST_POLL,
        ST_GAP3,
        ST_DONE
    } state_t;

    // Erase frame, left-aligned so the opcode is shifted out first.
    function automatic logic [31:0] erase_frame(input logic [1:0] op, input logic [23:0] addr);
        case (op)
            OP_SECTOR: return {CMD_SECTOR_ERASE, addr};
            OP_BLOCK:  return {CMD_BLOCK_ERASE, addr};
            default:   return {CMD_CHIP_ERASE, 24'h000000};
        endcase
    endfunction

    // Chip erase is opcode only; sector/block erase carry a 24-bit address.
    function automatic logic [5:0] erase_len(input logic [1:0] op);
        return (op == OP_CHIP) ? 6'd8 : 6'd32;
    endfunction

endpackage

// File: rtl/spi_frame_shift.sv
// rtl/spi_frame_shift.sv - SPI mode-0 frame engine: up to 32 tx bits, last 8 rx bits kept
module spi_frame_shift #(
    parameter int SCK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] tx_data,
    input  logic [5:0]  tx_len,
    input  logic        spi_miso,
    output logic        spi_sck,
    output logic        cs_n,
    output logic        spi_mosi,
    output logic [7:0]  rx_byte,
    output logic        frame_done
);

    localparam logic [15:0] DIV_LAST = 16'(SCK_DIV - 1);

    logic        active;
    logic [15:0] div_cnt;
    logic [5:0]  bits_left;
    logic [31:0] shreg;
    logic        tick;

    // tick marks every SCK half-period boundary while a frame is running
    assign tick       = active && (div_cnt == DIV_LAST);
    // after the last falling edge one more half-period elapses, then cs_n is released
    assign frame_done = tick && !spi_sck && (bits_left == 6'd0);

    // Frame engine: first bit presented with cs_n fall, MOSI shifts on falling, MISO sampled on rising
    always_ff @(posedge clk) begin
        if (rst) begin
            active    <= 1'b0;
            cs_n      <= 1'b1;
            spi_sck   <= 1'b0;
            spi_mosi  <= 1'b0;
            div_cnt   <= 16'd0;
            bits_left <= 6'd0;
            shreg     <= 32'd0;
            rx_byte   <= 8'h00;
        end else if (load && !active) begin
            active    <= 1'b1;
            cs_n      <= 1'b0;
            spi_sck   <= 1'b0;
            spi_mosi  <= tx_data[31];
            div_cnt   <= 16'd0;
            bits_left <= tx_len;
            shreg     <= tx_data;
        end else if (active) begin
            div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
            if (tick) begin
                if (!spi_sck) begin
                    if (bits_left != 6'd0) begin
                        spi_sck <= 1'b1;
                        rx_byte <= {rx_byte[6:0], spi_miso};
                    end else begin
                        active   <= 1'b0;
                        cs_n     <= 1'b1;
                        spi_mosi <= 1'b0;
                    end
                end else begin
                    spi_sck   <= 1'b0;
                    bits_left <= bits_left - 6'd1;
                    shreg     <= {shreg[30:0], 1'b0};
                    spi_mosi  <= shreg[30];
                end
            end
        end
    end

endmodule

// File: rtl/spi_flash_erase_seq.sv
// rtl/spi_flash_erase_seq.sv - WREN/erase/status-poll sequencer; SPI_FLASH_POLL_TIMEOUT_EN adds poll timeout
module spi_flash_erase_seq
    import spi_flash_pkg::*;
#(
    parameter int          SCK_DIV  = 2,
    parameter int          CS_GAP   = 4,
    parameter logic [23:0] POLL_MAX = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [23:0] addr,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  status,
    output logic        spi_sck,
    output logic        cs_n,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam logic [15:0] GAP_LAST = 16'(CS_GAP - 1);

    state_t      state, state_next;
    logic [1:0]  op_q;
    logic [23:0] addr_q;
    logic        err_q;
    logic [7:0]  status_q;
    logic [15:0] gap_cnt;
    logic        in_gap, gap_last;
    logic        frame_load, frame_done;
    logic [31:0] frame_data;
    logic [5:0]  frame_len;
    logic [7:0]  rx_byte;
    logic        poll_timeout;

    spi_frame_shift #(.SCK_DIV(SCK_DIV)) u_shift (
        .clk        (clk),
        .rst        (rst),
        .load       (frame_load),
        .tx_data    (frame_data),
        .tx_len     (frame_len),
        .spi_miso   (spi_miso),
        .spi_sck    (spi_sck),
        .cs_n       (cs_n),
        .spi_mosi   (spi_mosi),
        .rx_byte    (rx_byte),
        .frame_done (frame_done)
    );

    assign in_gap   = (state == ST_GAP1) || (state == ST_GAP2) || (state == ST_GAP3);
    assign gap_last = in_gap && (gap_cnt == GAP_LAST);

`ifdef SPI_FLASH_POLL_TIMEOUT_EN
    logic [23:0] poll_cnt;

    // Count completed polls of the current erase
    always_ff @(posedge clk) begin
        if (rst || (state == ST_IDLE && start))
            poll_cnt <= 24'd0;
        else if (state == ST_POLL && frame_done)
            poll_cnt <= poll_cnt + 24'd1;
    end

    assign poll_timeout = rx_byte[0] && ((poll_cnt + 24'd1) >= POLL_MAX);
`else
    logic unused_poll_max;
    assign unused_poll_max = ^POLL_MAX;
    assign poll_timeout    = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Gap timer: cs_n stays high for CS_GAP cycles, the next frame loads on the last one
    always_ff @(posedge clk) begin
        if (rst || !in_gap || gap_last) gap_cnt <= 16'd0;
        else                            gap_cnt <= gap_cnt + 16'd1;
    end

    // Request capture, error flag and status byte
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= OP_CHIP;
            addr_q   <= 24'd0;
            err_q    <= 1'b0;
            status_q <= 8'h00;
        end else begin
            if (state == ST_IDLE && start) begin
                op_q   <= op;
                addr_q <= addr;
                err_q  <= (op == OP_RSVD);
            end
            if (state == ST_POLL && frame_done) begin
                status_q <= rx_byte;
                if (poll_timeout) err_q <= 1'b1;
            end
        end
    end

    // Next state and frame launch; a frame is loaded on the cycle its state is entered
    always_comb begin
        state_next = state;
        frame_load = 1'b0;
        frame_data = 32'd0;
        frame_len  = 6'd0;
        case (state)
            ST_IDLE: if (start) begin
                state_next = ST_WREN;
                if (op != OP_RSVD) begin
                    frame_load = 1'b1;
                    frame_data = {CMD_WREN, 24'h000000};
                    frame_len  = 6'd8;
                end
            end
            ST_WREN: begin
                if (op_q == OP_RSVD) state_next = ST_DONE;
                else if (frame_done) state_next = ST_GAP1;
            end
            ST_GAP1: if (gap_last) begin
                state_next = ST_ERASE;
                frame_load = 1'b1;
                frame_data = erase_frame(op_q, addr_q);
                frame_len  = erase_len(op_q);
            end
            ST_ERASE: if (frame_done) state_next = ST_GAP2;
            ST_GAP2, ST_GAP3: if (gap_last) begin
                state_next = ST_POLL;
                frame_load = 1'b1;
                frame_data = {CMD_RDSR, 24'h000000};
                frame_len  = 6'd16;
            end
            ST_POLL: if (frame_done) begin
                if (!rx_byte[0] || poll_timeout) state_next = ST_DONE;
                else                             state_next = ST_GAP3;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy   = (state != ST_IDLE) && (state != ST_DONE);
    assign done   = (state == ST_DONE);
    assign err    = done && err_q;
    assign status = status_q;

endmodule
